counter_cmd_ctrl: RTL and testbench

COUNTER_CMD_CTRL -- requirements
Module: counter_cmd_ctrl

---
 rtl/counter_ctrl_pkg.sv | 30 +++
 rtl/counter_cmd_ctrl_if.sv | 33 +++
 rtl/btn_debounce.sv | 53 +++++
 rtl/counter_cmd_ctrl.sv | 172 +++++++++++++++++
 tb/tb_counter_cmd_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/counter_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// counter_ctrl_pkg
// Shared types and defaults for the counter command controller.
//   state_e : direction FSM state (IDLE / HOLD / REPEAT)
//   dir_e   : active direction (UP / DN)
//   DEF_*   : default debounce and auto-repeat timing, in clk cycles
//   max2()  : helper used to size the shared repeat timer
// -----------------------------------------------------------------------------
package counter_ctrl_pkg;

  localparam int DEF_DEB_CYCLES = 4;
  localparam int DEF_REP_DELAY  = 16;
  localparam int DEF_REP_RATE   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/counter_cmd_ctrl_if.sv
// -----------------------------------------------------------------------------
// counter_cmd_ctrl_if
// Bundles the raw button / switch inputs and the command outputs of
// counter_cmd_ctrl.
//   btn_up, btn_dn, btn_load : raw (bouncy) buttons
//   sw_in[4:0]               : switch value to load
//   up, down, load           : one-cycle commands to the downstream counter
//   IN[4:0]                  : load value, held between loads
// master : drives the buttons/switches and observes the commands
// slave  : the controller itself
// -----------------------------------------------------------------------------
interface counter_cmd_ctrl_if;

  logic       btn_up;
  logic       btn_dn;
  logic       btn_load;
  logic [4:0] sw_in;
  logic       up;
  logic       down;
  logic       load;
  logic [4:0] IN;

  modport master (
    output btn_up, btn_dn, btn_load, sw_in,
    input  up, down, load, IN
  );

  modport slave (
    input  btn_up, btn_dn, btn_load, sw_in,
    output up, down, load, IN
  );

endinterface

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Counts consecutive samples of raw that differ from the current filtered
// level; the level flips on the edge where the DEB_CYCLES-th consecutive
// differing sample is taken. Any sample equal to the current level restarts
// the count. raw is expected to be synchronous to clk already.
//   clk   : system clock
//   rst   : synchronous active-high reset (level and count to 0)
//   raw   : raw button input
//   level : filtered button level
// -----------------------------------------------------------------------------
module btn_debounce
  import counter_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (raw != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = raw;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/counter_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// counter_cmd_ctrl
// Turns three bouncy buttons into clean one-cycle up/down/load commands for a
// downstream 5-bit counter, with hold-to-auto-repeat on the direction buttons.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : counter_cmd_ctrl_if.slave (buttons, sw_in in; up/down/load/IN out)
//
// Direction FSM
//   state  | meaning
//   IDLE   | no direction active; waiting for a filtered rising edge
//   HOLD   | first pulse sent; waiting REP_DELAY cycles of continued hold
//   REPEAT | auto-repeat; one pulse every REP_RATE cycles while held
//
// Priority is load > down > up. Filtered load high forces IDLE and blocks
// direction pulses. Commands only start on filtered rising edges, so a button
// that is still held when the FSM drops back to IDLE stays silent until it is
// released and pressed again.
// -----------------------------------------------------------------------------
module counter_cmd_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int REP_DELAY  = DEF_REP_DELAY,
  parameter int REP_RATE   = DEF_REP_RATE
) (
  input logic               clk,
  input logic               rst,
  counter_cmd_ctrl_if.slave bus
);

  // One timer serves both HOLD and REPEAT; it is compared against a limit
  // and never counts past the larger one, so it cannot wrap.
  localparam int TMR_MAX = max2(REP_DELAY, REP_RATE);
  localparam int TW      = $clog2(TMR_MAX + 1);
  localparam logic [TW-1:0] DELAY_LAST = TW'(REP_DELAY - 1);
  localparam logic [TW-1:0] RATE_LAST  = TW'(REP_RATE - 1);

  logic lvl_up, lvl_dn, lvl_ld;
  logic prev_up_q, prev_dn_q, prev_ld_q;
  logic rise_up, rise_dn, rise_ld;
  logic active;
  logic [TW-1:0] tmr_last;

  state_e        state_q, state_d;
  dir_e          dir_q, dir_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          up_q, up_d;
  logic          down_q, down_d;
  logic          load_q, load_d;
  logic [4:0]    in_q, in_d;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.btn_up),
    .level (lvl_up)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.btn_dn),
    .level (lvl_dn)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ld (
    .clk   (clk),
    .rst   (rst),
    .raw   (bus.btn_load),
    .level (lvl_ld)
  );

  assign rise_up  = lvl_up & ~prev_up_q;
  assign rise_dn  = lvl_dn & ~prev_dn_q;
  assign rise_ld  = lvl_ld & ~prev_ld_q;
  assign active   = (dir_q == DIR_DN) ? lvl_dn : lvl_up;
  assign tmr_last = (state_q == ST_REPEAT) ? RATE_LAST : DELAY_LAST;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    up_d    = 1'b0;
    down_d  = 1'b0;
    load_d  = rise_ld;
    in_d    = rise_ld ? bus.sw_in : in_q;

    if (lvl_ld) begin
      state_d = ST_IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Simultaneous rises resolve to DN.
          if (rise_dn) begin
            down_d  = 1'b1;
            dir_d   = DIR_DN;
            state_d = ST_HOLD;
            timer_d = '0;
          end else if (rise_up) begin
            up_d    = 1'b1;
            dir_d   = DIR_UP;
            state_d = ST_HOLD;
            timer_d = '0;
          end
        end

        ST_HOLD, ST_REPEAT: begin
          if ((dir_q == DIR_UP) && rise_dn) begin
            // Down overrides an active up; the up press is simply ignored
            // in the opposite case.
            down_d  = 1'b1;
            dir_d   = DIR_DN;
            state_d = ST_HOLD;
            timer_d = '0;
          end else if (!active) begin
            state_d = ST_IDLE;
            timer_d = '0;
          end else if (timer_q >= tmr_last) begin
            if (dir_q == DIR_DN) begin
              down_d = 1'b1;
            end else begin
              up_d = 1'b1;
            end
            state_d = ST_REPEAT;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end

        default: begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_UP;
      timer_q   <= '0;
      prev_up_q <= 1'b0;
      prev_dn_q <= 1'b0;
      prev_ld_q <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      load_q    <= 1'b0;
      in_q      <= 5'b00000;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      timer_q   <= timer_d;
      prev_up_q <= lvl_up;
      prev_dn_q <= lvl_dn;
      prev_ld_q <= lvl_ld;
      up_q      <= up_d;
      down_q    <= down_d;
      load_q    <= load_d;
      in_q      <= in_d;
    end
  end

  assign bus.up   = up_q;
  assign bus.down = down_q;
  assign bus.load = load_q;
  assign bus.IN   = in_q;

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_cmd_ctrl
// Directed bench for counter_cmd_ctrl (DEB=4, REP_DELAY=16, REP_RATE=4).
// Cycle k is the interval after the k-th rising edge counted from the point
// where a scenario's stimulus is first applied; inputs set in cycle k are
// first sampled at edge k+1. A small saturating 5-bit counter driven by the
// command outputs stands in for the downstream counter.
// -----------------------------------------------------------------------------
module tb_counter_cmd_ctrl;

  logic clk = 1'b0;
  logic rst;

  counter_cmd_ctrl_if bus_if ();

  counter_cmd_ctrl #(
    .DEB_CYCLES (4),
    .REP_DELAY  (16),
    .REP_RATE   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [4:0] cnt5;
  logic       cnt_low, cnt_high;

  always @(posedge clk) begin
    if (rst) begin
      cnt5 <= 5'd0;
    end else if (bus_if.load) begin
      cnt5 <= bus_if.IN;
    end else if (bus_if.down) begin
      if (cnt5 != 5'd0) cnt5 <= cnt5 - 5'd1;
    end else if (bus_if.up) begin
      if (cnt5 != 5'd31) cnt5 <= cnt5 + 5'd1;
    end
  end

  assign cnt_low  = (cnt5 == 5'd0);
  assign cnt_high = (cnt5 == 5'd31);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;

    // Reset with load held and a non-zero switch value: nothing may escape.
    rst             = 1'b1;
    bus_if.btn_up   = 1'b0;
    bus_if.btn_dn   = 1'b0;
    bus_if.btn_load = 1'b1;
    bus_if.sw_in    = 5'h1f;
    repeat (6) tick();
    chk1("rst_up", bus_if.up, 1'b0);
    chk1("rst_down", bus_if.down, 1'b0);
    chk1("rst_load", bus_if.load, 1'b0);
    chk5("rst_in", bus_if.IN, 5'b00000);

    rst             = 1'b0;
    bus_if.btn_load = 1'b0;
    bus_if.sw_in    = 5'h00;
    repeat (8) tick();
    chk1("quiet_load", bus_if.load, 1'b0);
    chk5("quiet_in", bus_if.IN, 5'b00000);

    // Bounce: 2 high / 2 low for 12 cycles, never 4 stable samples.
    for (int i = 0; i < 24; i++) begin
      bus_if.btn_up = (i < 12) && ((i % 4) < 2);
      tick();
      chk1("bounce_up", bus_if.up, 1'b0);
    end

    // Hold and auto-repeat: btn_up high in cycles 0..44. The repeat slot at
    // cycle 49 falls on the same edge the filtered level drops, so it is not
    // checked; everything after the drop must be quiet.
    bus_if.btn_up = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 45) bus_if.btn_up = 1'b0;
      if (k != 49)
        chk1("hold_up", bus_if.up, k inside {5, 21, 25, 29, 33, 37, 41, 45});
      chk1("hold_down", bus_if.down, 1'b0);
    end

    // Load 3 with a 6-cycle press.
    bus_if.sw_in    = 5'b00011;
    bus_if.btn_load = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 6) bus_if.btn_load = 1'b0;
      chk1("load_pulse", bus_if.load, k == 5);
      chk1("load_up", bus_if.up, 1'b0);
      chk1("load_down", bus_if.down, 1'b0);
      chk5("load_in", bus_if.IN, (k >= 5) ? 5'b00011 : 5'b00000);
    end
    bus_if.sw_in = 5'h1a;
    repeat (5) tick();
    chk5("in_held", bus_if.IN, 5'b00011);

    // Up+down together -> down only; load at cycle 27 -> load pulse at 32,
    // down suppressed; load released at 40 with up/down still held -> silence.
    bus_if.sw_in  = 5'b00111;
    bus_if.btn_up = 1'b1;
    bus_if.btn_dn = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 27) bus_if.btn_load = 1'b1;
      if (k == 40) bus_if.btn_load = 1'b0;
      if (k == 55) begin
        bus_if.btn_up = 1'b0;
        bus_if.btn_dn = 1'b0;
      end
      chk1("prio_down", bus_if.down, k inside {5, 21, 25, 29});
      chk1("prio_up", bus_if.up, 1'b0);
      chk1("prio_load", bus_if.load, k == 32);
      chk5("prio_in", bus_if.IN, (k >= 32) ? 5'b00111 : 5'b00011);
    end
    repeat (4) tick();

    // Down pressed during an up hold takes over and restarts the delay.
    bus_if.btn_up = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      tick();
      if (k == 8) bus_if.btn_dn = 1'b1;
      chk1("switch_up", bus_if.up, k == 5);
      chk1("switch_down", bus_if.down, k inside {13, 29, 33});
    end
    bus_if.btn_up = 1'b0;
    bus_if.btn_dn = 1'b0;
    repeat (8) tick();

    // Reset for one cycle mid-REPEAT (sampled at edge 29, where a down pulse
    // was due); the held button re-debounces and fires 5 edges later.
    bus_if.btn_dn = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 28) rst = 1'b1;
      if (k == 29) rst = 1'b0;
      chk1("rstmid_down", bus_if.down, k inside {5, 21, 25, 34});
      chk1("rstmid_up", bus_if.up, 1'b0);
      chk1("rstmid_load", bus_if.load, 1'b0);
      chk5("rstmid_in", bus_if.IN, (k >= 29) ? 5'b00000 : 5'b00111);
    end
    bus_if.btn_dn = 1'b0;
    repeat (8) tick();

    // Integration with the downstream counter.
    bus_if.sw_in    = 5'b00011;
    bus_if.btn_load = 1'b1;
    repeat (6) tick();
    bus_if.btn_load = 1'b0;
    repeat (4) tick();
    chk5("int_loaded", cnt5, 5'b00011);

    bus_if.btn_dn = 1'b1;
    guard = 0;
    while ((cnt5 != 5'd0) && (guard < 200)) begin
      tick();
      guard++;
    end
    chk5("int_zero", cnt5, 5'b00000);
    chk1("int_low", cnt_low, 1'b1);
    bus_if.btn_dn = 1'b0;
    repeat (8) tick();

    bus_if.btn_up = 1'b1;
    guard = 0;
    while ((cnt5 != 5'd31) && (guard < 400)) begin
      tick();
      guard++;
    end
    chk5("int_full", cnt5, 5'b11111);
    chk1("int_high", cnt_high, 1'b1);
    bus_if.btn_up = 1'b0;
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
